// File: rtl/alu_mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Used by alu_mult_seq and mult_step.
package alu_mult_pkg;

    localparam int unsigned DEF_WIDTH = 16;

    // Smallest counter width satisfying 2^w > width
    function automatic int unsigned cnt_w_for(input int unsigned width);
        return $clog2(width + 1);
    endfunction

    localparam int unsigned DEF_CNT_W = cnt_w_for(DEF_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/mult_step.sv
// One shift-add iteration: conditional accumulate, then shift multiplicand
// left and multiplier right.
module mult_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [2*WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [2*WIDTH-1:0] mcand_o,
    output logic [WIDTH-1:0]   mplier_o,
    output logic               mplier_zero_o
);

    always_comb begin
        acc_o         = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
        mcand_o       = mcand_i << 1;
        mplier_o      = mplier_i >> 1;
        mplier_zero_o = (mplier_o == '0);
    end

endmodule

// File: rtl/alu_mult_seq.sv
// Iterative MUL/MULH sequencer for the execute stage (magnitude shift-add, sign fixup).
// Optional MULT_EARLY_EXIT_EN: leave RUN as soon as the remaining multiplier is zero.
module alu_mult_seq
    import alu_mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] prod_hi,
    output logic             err
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
`ifdef MULT_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
    logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [PW-1:0]    step_acc;
    logic [PW-1:0]    step_mcand;
    logic [WIDTH-1:0] step_mplier;
    logic             step_zero;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [PW-1:0]    acc_neg;
    logic             accept;

    mult_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i         (acc_q),
        .mcand_i       (mcand_q),
        .mplier_i      (mplier_q),
        .acc_o         (step_acc),
        .mcand_o       (step_mcand),
        .mplier_o      (step_mplier),
        .mplier_zero_o (step_zero)
    );

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned
    always_comb begin
        a_mag   = (signed_op && op_a[WIDTH-1]) ? (~op_a + WIDTH'(1)) : op_a;
        b_mag   = (signed_op && op_b[WIDTH-1]) ? (~op_b + WIDTH'(1)) : op_b;
        acc_neg = ~acc_q + PW'(1);
        accept  = start && (state_q == ST_IDLE) && !flush;
    end

    // Next-state and datapath update; flush overrides everything but err
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        neg_d     = neg_q;
        prod_lo_d = prod_lo_q;
        prod_hi_d = prod_hi_q;
        err_d     = start && (state_q != ST_IDLE);

        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, a_mag};
                        mplier_d = b_mag;
                        neg_d    = signed_op && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        cnt_d    = '0;
                        state_d  = ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_d    = step_acc;
                    mcand_d  = step_mcand;
                    mplier_d = step_mplier;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if ((cnt_q == LAST_CNT) || (EARLY_EXIT && step_zero)) begin
                        state_d = ST_SIGN;
                    end
                end
                ST_SIGN: begin
                    {prod_hi_d, prod_lo_d} = neg_q ? acc_neg : acc_q;
                    state_d                = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_SIGN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            neg_q     <= 1'b0;
            prod_lo_q <= '0;
            prod_hi_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            neg_q     <= neg_d;
            prod_lo_q <= prod_lo_d;
            prod_hi_q <= prod_hi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign prod_lo = prod_lo_q;
    assign prod_hi = prod_hi_q;
    // Pipeline must hold in the start cycle itself, before busy rises
    assign stall   = accept || busy_q;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Self-checking bench for alu_mult_seq: cycle-level behavioural model plus directed literals.
// Honours MULT_EARLY_EXIT_EN for latency expectations.
module tb_alu_mult_seq;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          signed_op;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          flush;
    logic          busy;
    logic          stall;
    logic          done;
    logic [W-1:0]  prod_lo;
    logic [W-1:0]  prod_hi;
    logic          err;

    alu_mult_seq #(
        .WIDTH (W),
        .CNT_W (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_op (signed_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .prod_lo   (prod_lo),
        .prod_hi   (prod_hi),
        .err       (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model state: an operation is "active" in cycles (op_start, op_done]
    bit          active   = 1'b0;
    int          op_done  = 0;
    logic [31:0] op_prod  = '0;
    logic [31:0] exp_prod = '0;
    bit          err_pend = 1'b0;

    int          seen_done_cyc  = -1;
    logic [31:0] seen_done_prod = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
        longint sa, sb;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        return 32'(sa * sb);
    endfunction

    // Start-to-done distance: full WIDTH iterations, or bit length of |b| with early exit
    function automatic int model_lat(input logic [W-1:0] b, input logic s);
        int mb, n;
        mb = (s && b[W-1]) ? (65536 - int'(b)) : int'(b);
        n  = 0;
        while (mb != 0) begin
            n++;
            mb = mb >> 1;
        end
`ifdef MULT_EARLY_EXIT_EN
        if (n == 0) n = 1;
        return n + 2;
`else
        return (n > W) ? 0 : W + 2;
`endif
    endfunction

    // Compare all outputs mid-cycle, advance the model with this cycle's inputs, then move to next cycle
    task automatic tick();
        bit exp_busy;
        @(negedge clk);
        if (active && cyc == op_done) exp_prod = op_prod;
        exp_busy = active && (cyc < op_done);
        check("busy", 32'(busy), 32'(exp_busy));
        check("stall", 32'(stall), 32'((start && !active && !flush) || exp_busy));
        check("done", 32'(done), 32'(active && cyc == op_done));
        check("err", 32'(err), 32'(err_pend));
        check("prod", {prod_hi, prod_lo}, exp_prod);
        if (done === 1'b1) begin
            seen_done_cyc  = cyc;
            seen_done_prod = {prod_hi, prod_lo};
        end
        if (rst) begin
            active   = 1'b0;
            exp_prod = '0;
            err_pend = 1'b0;
        end else begin
            err_pend = start && active;
            if (flush) begin
                active = 1'b0;
            end else if (!active && start) begin
                active  = 1'b1;
                op_done = cyc + model_lat(op_b, signed_op);
                op_prod = model_prod(op_a, op_b, signed_op);
            end else if (active && cyc == op_done) begin
                active = 1'b0;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output int c0);
        c0        = cyc;
        start     = 1'b1;
        op_a      = a;
        op_b      = b;
        signed_op = s;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int lat, output logic [31:0] p);
        for (int i = 0; i < 60; i++) begin
            if (seen_done_cyc > c0) break;
            tick();
        end
        if (seen_done_cyc > c0) begin
            lat = seen_done_cyc - c0;
            p   = seen_done_prod;
        end else begin
            lat = -1;
            p   = 'x;
            check("done_timeout", 32'(0), 32'(1));
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input int exp_lat, input logic [31:0] exp_p, input string name);
        int c0, lat;
        logic [31:0] p;
        launch(a, b, s, c0);
        wait_done(c0, lat, p);
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_prod"}, p, exp_p);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] corners [5];
        corners[0] = 16'h0000;
        corners[1] = 16'h0001;
        corners[2] = 16'h8000;
        corners[3] = 16'hFFFF;
        corners[4] = 16'h7FFF;
        if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
        return W'($urandom);
    endfunction

    initial begin
        int c0, lat;
        logic [31:0] p;
        rst       = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        op_a      = '0;
        op_b      = '0;
        flush     = 1'b0;
        @(posedge clk);
        #1;
        tick();
        rst = 1'b0;
        tick();

        // Basic products and full-width corners
        run_op(16'd3, 16'd5, 1'b0, W + 2, 32'h0000_000F, "u3x5");
        run_op(16'hFFFD, 16'h0007, 1'b1, W + 2, 32'hFFFF_FFEB, "sm3x7");
        run_op(16'hFFFF, 16'hFFFF, 1'b0, W + 2, 32'hFFFE_0001, "uffff2");
        run_op(16'h8000, 16'h8000, 1'b1, W + 2, 32'h4000_0000, "smin2");
        run_op(16'h8000, 16'h0001, 1'b1, W + 2, 32'hFFFF_8000, "sminx1");

        // Flush in cycle 5: no done, product held, restart in cycle 6
        launch(16'd2, 16'd3, 1'b0, c0);
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy_c6", 32'(busy), 32'(0));
        check("flush_hold_prod", {prod_hi, prod_lo}, 32'hFFFF_8000);
        run_op(16'd5, 16'd5, 1'b0, W + 2, 32'h0000_0019, "after_flush");

        // Start while busy raises err for exactly one cycle, op unaffected
        launch(16'd4, 16'd4, 1'b0, c0);
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("err_c4", 32'(err), 32'(1));
        tick();
        check("err_c5", 32'(err), 32'(0));
        wait_done(c0, lat, p);
        check("busy_start_lat", 32'(lat), 32'(W + 2));
        check("busy_start_prod", p, 32'h0000_0010);

        // Reset in cycle 10 of an op clears outputs, no done follows
        launch(16'd7, 16'd9, 1'b0, c0);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_prod", {prod_hi, prod_lo}, 32'h0);
        check("rst_busy", 32'(busy), 32'(0));
        repeat (25) tick();

`ifdef MULT_EARLY_EXIT_EN
        run_op(16'd7, 16'd2, 1'b0, 4, 32'h0000_000E, "early7x2");
        run_op(16'd9, 16'd0, 1'b0, 3, 32'h0000_0000, "early9x0");
`else
        run_op(16'd7, 16'd2, 1'b0, W + 2, 32'h0000_000E, "full7x2");
        run_op(16'd9, 16'd0, 1'b0, W + 2, 32'h0000_0000, "full9x0");
`endif

        // Randomised traffic with occasional flush, reset and stray starts
        for (int i = 0; i < 4000; i++) begin
            start     = ($urandom_range(3) == 0);
            signed_op = 1'($urandom);
            op_a      = pick_operand();
            op_b      = pick_operand();
            flush     = ($urandom_range(59) == 0);
            rst       = ($urandom_range(299) == 0);
            tick();
        end
        start = 1'b0;
        flush = 1'b0;
        rst   = 1'b0;
        repeat (30) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_mult_seq.md
Name: alu_mult_seq

Overview:
Multi-cycle iterative shift-add multiplier controller that sequences MUL/MULH instructions in the execute stage.
- Accepts operands from the decode/execute boundary, stalls the pipeline while iterating, and returns a 2*WIDTH-bit product.
- Sits beside the single-cycle ALU.
- The pipeline control muxes its result onto the execute result bus when done is high.

Parameters:
WIDTH, 16, operand width in bits; product is 2*WIDTH bits.
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request a multiply; sampled only in IDLE
signed_op  input  1  1 = two's-complement operands, 0 = unsigned
op_a  input  WIDTH  multiplicand
op_b  input  WIDTH  multiplier
flush  input  1  synchronous abort from the branch/exception logic
busy  output  1  high in RUN and SIGN states
stall  output  1  combinational: (start & state==IDLE & ~flush) | busy
done  output  1  one-cycle pulse; product valid that cycle
prod_lo  output  WIDTH  low half of product
prod_hi  output  WIDTH  high half of product
err  output  1  registered one-cycle pulse when start is seen while busy

Behaviour:
- Clock/reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset: state=IDLE; counter, accumulator and operand registers=0; busy=0; done=0; err=0; prod_lo=0; prod_hi=0. A reset mid-operation discards the operation, and done is never asserted for it.
- States: IDLE, RUN, SIGN, DONE. Encoding comes from the package.
- IDLE, start=1, flush=0:
  - mcand (2*WIDTH) <= zero-extended |op_a|.
  - mplier (WIDTH) <= |op_b|.
  - neg <= signed_op & (op_a[MSB] ^ op_b[MSB]).
  - counter <= 0.
  - Go to RUN.
  - Magnitude of the most-negative value (e.g. 0x8000) is 2^(WIDTH-1) as unsigned; no overflow.
- RUN, each edge:
  - if mplier[0], acc <= acc + mcand (2*WIDTH-bit add, carry discarded).
  - mcand <<= 1; mplier >>= 1; counter++.
  - When counter == WIDTH-1, go to SIGN.
- SIGN, one edge: {prod_hi, prod_lo} <= neg ? -acc : acc. Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. prod_* hold their value until the next SIGN completes.
- Latency (start cycle = cycle 0): RUN occupies cycles 1..WIDTH, SIGN is cycle WIDTH+1, done is high in cycle WIDTH+2 (cycle 18 for WIDTH=16).
- start in RUN/SIGN/DONE: ignored. err pulses the following cycle. The in-flight op is unaffected.
- flush:
  - In any state, flush forces IDLE at the next edge.
  - done is suppressed; prod_* are unchanged.
  - flush together with start in IDLE: flush wins, nothing is loaded, and stall is 0.
- acc is cleared on every accepted start.
- Back-to-back: a start in the cycle after the DONE cycle (state IDLE) is accepted normally.

Optional Feature:
MULT_EARLY_EXIT_EN
- Defined: RUN also exits to SIGN at an edge whose next mplier value is 0. Minimum latency: done in cycle 3 (op_b=0). Product is identical.
- Undefined: fixed WIDTH iterations, deterministic latency WIDTH+2.

Decomposition:
- Package alu_mult_pkg holds:
  - state enum/localparams (IDLE=2'd0, RUN=2'd1, SIGN=2'd2, DONE=2'd3);
  - default WIDTH;
  - CNT_W helper constant.
- One sub-module, mult_step: combinational single iteration with
  - inputs acc, mcand, mplier;
  - outputs next acc, next mcand, next mplier, and next_mplier_zero.
- FSM, counter and registers stay in alu_mult_seq.

Test Plan:
1. unsigned 3*5, start 1 cycle -> stall 1 in cycles 0..17, done in cycle 18, prod_hi=0x0000, prod_lo=0x000F.
2. signed -3*7 (0xFFFD, 0x0007) -> prod_hi=0xFFFF, prod_lo=0xFFEB; unsigned 0xFFFF*0xFFFF -> prod_hi=0xFFFE, prod_lo=0x0001.
3. signed 0x8000*0x8000 -> prod_hi=0x4000, prod_lo=0x0000; signed 0x8000*0x0001 -> prod_hi=0xFFFF, prod_lo=0x8000.
4. start 2*3, flush in cycle 5 -> busy 0 from cycle 6, no done pulse, prod_* keep previous values; a new start in cycle 6 completes normally.
5. start 4*4, start again in cycle 3 -> err=1 in cycle 4 only, done in cycle 18 with prod_lo=0x0010; rst in cycle 10 of a later op -> all outputs 0 next cycle, no done.
6. With MULT_EARLY_EXIT_EN, 7*2 -> done in cycle 4, prod_lo=0x000E; 9*0 -> done in cycle 3, product 0. Without the macro, both finish in cycle 18.
